// File: rtl/seven_seg_scan_controller.sv
// seven_seg_scan_controller
// Scans NUM_DIGITS BCD digits onto one shared 7-segment decoder and a set of
// active-low common-anode drivers. New values are staged through a
// valid/ready port and committed only at frame boundaries, so one frame
// never shows a mix of old and new digits. Leading zeros are blanked.

module seven_seg_scan_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [4*NUM_DIGITS-1:0] i_digits_in,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic                    i_load_valid,
    output logic                    o_load_ready,
    output logic [3:0]              o_digit_out,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_dp,
    output logic                    o_frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    // Scan state
    logic [CNT_W-1:0]        r_count;
    logic [IDX_W-1:0]        r_idx;

    // Staged and displayed values
    logic [4*NUM_DIGITS-1:0] r_stagingDigits;
    logic [NUM_DIGITS-1:0]   r_stagingDp;
    logic [4*NUM_DIGITS-1:0] r_activeDigits;
    logic [NUM_DIGITS-1:0]   r_activeDp;
    logic                    r_pending;

    // Registered output stage
    logic                    r_frameDone;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [3:0]              r_digitOut;
    logic                    r_dp;

    // Combinational helpers
    logic                    w_tick;
    logic                    w_frameEnd;
    logic                    w_accept;
    logic [IDX_W-1:0]        w_top;
    logic                    w_blank;
    logic [3:0]              w_digitArr [NUM_DIGITS];
    logic [3:0]              w_curDigit;
    logic                    w_curDp;
    logic [NUM_DIGITS-1:0]   w_anSel;

    // A digit's dwell time ends on the last prescaler count, and the frame ends
    // when that happens on the last digit. Nothing advances while disabled.
    assign w_tick     = i_enable && (r_count == CNT_MAX);
    assign w_frameEnd = w_tick && (r_idx == IDX_MAX);

    // The staging register is free whenever nothing is waiting to commit.
    assign o_load_ready = !r_pending;
    assign w_accept     = i_load_valid && !r_pending;

    // Prescaler: counts dwell cycles for the current digit and holds while disabled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (w_tick) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Digit index: steps once per dwell period and wraps at the frame boundary,
    // which also covers digit counts that are not a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx <= '0;
        end else if (w_tick) begin
            if (w_frameEnd) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Load handshake and frame-boundary commit. Accept needs pending low and
    // commit needs pending high, so the two never coincide; a value accepted
    // on a boundary edge waits for the following boundary.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stagingDigits <= '0;
            r_stagingDp     <= '0;
            r_activeDigits  <= '0;
            r_activeDp      <= '0;
            r_pending       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_stagingDigits <= i_digits_in;
                r_stagingDp     <= i_dp_in;
                r_pending       <= 1'b1;
            end else if (w_frameEnd && r_pending) begin
                r_activeDigits  <= r_stagingDigits;
                r_activeDp      <= r_stagingDp;
                r_pending       <= 1'b0;
            end
        end
    end

    // Frame-done pulse follows the boundary edge by exactly one cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_frameEnd;
        end
    end

    // Split the packed committed value into per-digit nibbles.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_digitArr[i] = r_activeDigits[4*i +: 4];
        end
    end

    // Highest significant position: the last digit that is nonzero or carries
    // a decimal point. Defaults to 0 so digit 0 is always shown.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((r_activeDigits[4*i +: 4] != 4'h0) || r_activeDp[i]) begin
                w_top = IDX_W'(i);
            end
        end
    end

    // Select the current digit's value, decimal point and anode pattern.
    always_comb begin
        w_curDigit = w_digitArr[r_idx];
        w_curDp    = r_activeDp[r_idx];
        w_anSel    = ~(NUM_DIGITS'(1) << r_idx);
        w_blank    = (r_idx > w_top);
    end

    // Output stage: registered so the drivers see no combinational path from
    // the inputs. Disabled or blanked positions turn every anode off.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_an       <= '1;
            r_digitOut <= 4'hF;
            r_dp       <= 1'b1;
        end else if (!i_enable || w_blank) begin
            r_an       <= '1;
            r_digitOut <= 4'hF;
            r_dp       <= 1'b1;
        end else begin
            r_an       <= w_anSel;
            r_digitOut <= w_curDigit;
            r_dp       <= ~w_curDp;
        end
    end

    assign o_an         = r_an;
    assign o_digit_out  = r_digitOut;
    assign o_dp         = r_dp;
    assign o_frame_done = r_frameDone;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// tb_seven_seg_scan_controller
// Directed bench for the 4-digit scan controller with a short refresh divider.
// One task per scenario; expected frames are written out per digit by hand.

module tb_seven_seg_scan_controller;

    localparam int NUM_DIGITS  = 4;
    localparam int REFRESH_DIV = 4;
    localparam int FRAME       = NUM_DIGITS * REFRESH_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] digitsIn = '0;
    logic [3:0]  dpIn = '0;
    logic        loadValid = 1'b0;
    logic        loadReady;
    logic [3:0]  digitOut;
    logic [3:0]  an;
    logic        dp;
    logic        frameDone;

    int checks = 0;
    int errors = 0;

    logic [3:0] capAn  [FRAME];
    logic [3:0] capDig [FRAME];
    logic       capDp  [FRAME];
    logic       capFd  [FRAME];
    logic       capRdy [FRAME];

    seven_seg_scan_controller #(
        .NUM_DIGITS (NUM_DIGITS),
        .REFRESH_DIV(REFRESH_DIV)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_enable    (enable),
        .i_digits_in (digitsIn),
        .i_dp_in     (dpIn),
        .i_load_valid(loadValid),
        .o_load_ready(loadReady),
        .o_digit_out (digitOut),
        .o_an        (an),
        .o_dp        (dp),
        .o_frame_done(frameDone)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Wait for the next frame_done pulse, bounded.
    task automatic waitFrameDone(input string tag);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (frameDone === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s frame_done wait: got no pulse in 100 cycles, required a pulse", tag);
        end
    endtask

    // Record one full frame of outputs, one sample per cycle.
    task automatic captureFrame();
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            capAn[k]  = an;
            capDig[k] = digitOut;
            capDp[k]  = dp;
            capFd[k]  = frameDone;
            capRdy[k] = loadReady;
        end
    endtask

    // Wait for ready, then present a one-cycle load.
    task automatic doLoad(input logic [15:0] d, input logic [3:0] p, input string tag);
        int n;
        n = 0;
        while (loadReady !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        loadValid = 1'b1;
        digitsIn  = d;
        dpIn      = p;
        @(negedge clk);
        loadValid = 1'b0;
        checks++;
        if (loadReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s ready after accept: got %b, expected 0", tag, loadReady);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 4'b1111 || digitOut !== 4'hF || dp !== 1'b1 || frameDone !== 1'b0 || loadReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset state: got an=%b dig=%h dp=%b fd=%b rdy=%b, expected an=1111 dig=f dp=1 fd=0 rdy=1",
                     an, digitOut, dp, frameDone, loadReady);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle_frame();
        logic [3:0] expAn  [4];
        logic [3:0] expDig [4];
        expAn  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        expDig = '{4'h0, 4'hF, 4'hF, 4'hF};
        waitFrameDone("idle");
        captureFrame();
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (capAn[k] !== expAn[k/4] || capDig[k] !== expDig[k/4] || capDp[k] !== 1'b1 || capFd[k] !== (k == FRAME-1)) begin
                errors++;
                $display("[TB] FAIL idle slot %0d: got an=%b dig=%h dp=%b fd=%b, expected an=%b dig=%h dp=1 fd=%b",
                         k, capAn[k], capDig[k], capDp[k], capFd[k], expAn[k/4], expDig[k/4], (k == FRAME-1));
            end
        end
    endtask

    task automatic test_load_commit();
        logic [3:0] expAn  [4];
        logic [3:0] expDig [4];
        int  n;
        bit  seen;
        bit  badReady;
        bit  badDisp;
        expAn    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        expDig   = '{4'h4, 4'h3, 4'h2, 4'h1};
        n        = 0;
        seen     = 1'b0;
        badReady = 1'b0;
        badDisp  = 1'b0;
        repeat (5) @(negedge clk);
        doLoad(16'h1234, 4'b0000, "load1234");
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (frameDone === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (loadReady !== 1'b0) badReady = 1'b1;
                if (!((an === 4'b1110 && digitOut === 4'h0) || (an === 4'b1111 && digitOut === 4'hF))) badDisp = 1'b1;
            end
        end
        checks++;
        if (!seen || badReady || badDisp) begin
            errors++;
            $display("[TB] FAIL load1234 pending: got seen=%b badReady=%b badDisp=%b, expected 1 0 0", seen, badReady, badDisp);
        end
        checks++;
        if (loadReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load1234 ready after commit: got %b, expected 1", loadReady);
        end
        captureFrame();
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (capAn[k] !== expAn[k/4] || capDig[k] !== expDig[k/4] || capDp[k] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL load1234 slot %0d: got an=%b dig=%h dp=%b, expected an=%b dig=%h dp=1",
                         k, capAn[k], capDig[k], capDp[k], expAn[k/4], expDig[k/4]);
            end
        end
    endtask

    task automatic test_blanking();
        logic [3:0] expAn  [4];
        logic [3:0] expDig [4];
        logic       expDp  [4];

        doLoad(16'h0050, 4'b0000, "blank0050");
        waitFrameDone("blank0050");
        captureFrame();
        expAn  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        expDig = '{4'h0, 4'h5, 4'hF, 4'hF};
        expDp  = '{1'b1, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (capAn[k] !== expAn[k/4] || capDig[k] !== expDig[k/4] || capDp[k] !== expDp[k/4]) begin
                errors++;
                $display("[TB] FAIL blank0050 slot %0d: got an=%b dig=%h dp=%b, expected an=%b dig=%h dp=%b",
                         k, capAn[k], capDig[k], capDp[k], expAn[k/4], expDig[k/4], expDp[k/4]);
            end
        end

        doLoad(16'h0000, 4'b1000, "dp3");
        waitFrameDone("dp3");
        captureFrame();
        expAn  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        expDig = '{4'h0, 4'h0, 4'h0, 4'h0};
        expDp  = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (capAn[k] !== expAn[k/4] || capDig[k] !== expDig[k/4] || capDp[k] !== expDp[k/4]) begin
                errors++;
                $display("[TB] FAIL dp3 slot %0d: got an=%b dig=%h dp=%b, expected an=%b dig=%h dp=%b",
                         k, capAn[k], capDig[k], capDp[k], expAn[k/4], expDig[k/4], expDp[k/4]);
            end
        end

        doLoad(16'h0000, 4'b0010, "dp1");
        waitFrameDone("dp1");
        captureFrame();
        expAn  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
        expDig = '{4'h0, 4'h0, 4'hF, 4'hF};
        expDp  = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (capAn[k] !== expAn[k/4] || capDig[k] !== expDig[k/4] || capDp[k] !== expDp[k/4]) begin
                errors++;
                $display("[TB] FAIL dp1 slot %0d: got an=%b dig=%h dp=%b, expected an=%b dig=%h dp=%b",
                         k, capAn[k], capDig[k], capDp[k], expAn[k/4], expDig[k/4], expDp[k/4]);
            end
        end
    endtask

    task automatic test_non_bcd();
        logic [3:0] expAn  [4];
        logic [3:0] expDig [4];
        expAn  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        expDig = '{4'hA, 4'h0, 4'h0, 4'hC};
        doLoad(16'hC00A, 4'b0000, "nonbcd");
        waitFrameDone("nonbcd");
        captureFrame();
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (capAn[k] !== expAn[k/4] || capDig[k] !== expDig[k/4] || capDp[k] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL nonbcd slot %0d: got an=%b dig=%h dp=%b, expected an=%b dig=%h dp=1",
                         k, capAn[k], capDig[k], capDp[k], expAn[k/4], expDig[k/4]);
            end
        end
    endtask

    // Display holds C00A here: digit 2 shows 0, digit 3 shows C.
    task automatic test_enable_pause();
        bit         anyLit;
        bit         anyFd;
        logic [3:0] eAn;
        logic [3:0] eDig;
        anyLit = 1'b0;
        anyFd  = 1'b0;
        waitFrameDone("pause");
        repeat (9) @(negedge clk);
        checks++;
        if (an !== 4'b1011 || digitOut !== 4'h0) begin
            errors++;
            $display("[TB] FAIL pause before drop: got an=%b dig=%h, expected an=1011 dig=0", an, digitOut);
        end
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (an !== 4'b1111 || digitOut !== 4'hF || dp !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pause dark: got an=%b dig=%h dp=%b, expected an=1111 dig=f dp=1", an, digitOut, dp);
        end
        repeat (9) begin
            @(negedge clk);
            if (an !== 4'b1111) anyLit = 1'b1;
            if (frameDone !== 1'b0) anyFd = 1'b1;
        end
        checks++;
        if (anyLit || anyFd) begin
            errors++;
            $display("[TB] FAIL pause hold: got lit=%b fd=%b, expected 0 0", anyLit, anyFd);
        end
        enable = 1'b1;
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            eAn  = (j <= 3) ? 4'b1011 : 4'b0111;
            eDig = (j <= 3) ? 4'h0 : 4'hC;
            checks++;
            if (an !== eAn || digitOut !== eDig || frameDone !== (j == 7)) begin
                errors++;
                $display("[TB] FAIL resume step %0d: got an=%b dig=%h fd=%b, expected an=%b dig=%h fd=%b",
                         j, an, digitOut, frameDone, eAn, eDig, (j == 7));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        loadValid = 1'b1;
        digitsIn  = 16'h1111;
        dpIn      = 4'b0000;
        @(negedge clk);
        checks++;
        if (loadReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b first accept: got ready=%b, expected 0", loadReady);
        end
        digitsIn = 16'h2222;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (frameDone === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || loadReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b commit 1111: got seen=%b ready=%b, expected 1 1", seen, loadReady);
        end
        captureFrame();
        loadValid = 1'b0;
        checks++;
        if (capRdy[0] !== 1'b0 || capRdy[FRAME-1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b second accept: got ready first=%b last=%b, expected 0 1", capRdy[0], capRdy[FRAME-1]);
        end
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (capAn[k] !== ~(4'b0001 << (k/4)) || capDig[k] !== 4'h1) begin
                errors++;
                $display("[TB] FAIL b2b 1111 slot %0d: got an=%b dig=%h, expected an=%b dig=1",
                         k, capAn[k], capDig[k], ~(4'b0001 << (k/4)));
            end
        end
        captureFrame();
        for (int k = 0; k < FRAME; k++) begin
            checks++;
            if (capAn[k] !== ~(4'b0001 << (k/4)) || capDig[k] !== 4'h2) begin
                errors++;
                $display("[TB] FAIL b2b 2222 slot %0d: got an=%b dig=%h, expected an=%b dig=2",
                         k, capAn[k], capDig[k], ~(4'b0001 << (k/4)));
            end
        end
    endtask

    task automatic test_reset_pending();
        logic [3:0] expAn  [4];
        logic [3:0] expDig [4];
        expAn  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        expDig = '{4'h0, 4'hF, 4'hF, 4'hF};
        repeat (3) @(negedge clk);
        doLoad(16'h9876, 4'b1111, "rstpend");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'b1111 || digitOut !== 4'hF || dp !== 1'b1 || frameDone !== 1'b0 || loadReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstpend state: got an=%b dig=%h dp=%b fd=%b rdy=%b, expected an=1111 dig=f dp=1 fd=0 rdy=1",
                     an, digitOut, dp, frameDone, loadReady);
        end
        reset = 1'b0;
        waitFrameDone("rstpend");
        for (int f = 0; f < 2; f++) begin
            captureFrame();
            for (int k = 0; k < FRAME; k++) begin
                checks++;
                if (capAn[k] !== expAn[k/4] || capDig[k] !== expDig[k/4] || capDp[k] !== 1'b1 || capRdy[k] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rstpend frame %0d slot %0d: got an=%b dig=%h dp=%b rdy=%b, expected an=%b dig=%h dp=1 rdy=1",
                             f, k, capAn[k], capDig[k], capDp[k], capRdy[k], expAn[k/4], expDig[k/4]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_frame();
        test_load_commit();
        test_blanking();
        test_non_bcd();
        test_enable_pause();
        test_back_to_back();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
